// File: rtl/pid_mc.sv
// rtl/pid_mc.sv - time-multiplexed multi-channel PID controller sharing one multiplier
//
// Optional feature macro: PID_DEADBAND_EN (per-channel error deadband on field 4)
//
// Ports:
//   clk            clock
//   rstb           synchronous active-low reset
//   write_enable   active-low register write strobe
//   iterate_enable high = run channel sweeps continuously
//   reg_addr       [2:0] field, [3 +: CH_W] channel, upper bits ignored
//   reg_data       register write data
//   target         per-channel setpoints, ch c at [c*D_WIDTH +: D_WIDTH]
//   measurement    per-channel process variables, same packing
//   out            controller output of channel out_ch
//   out_ch         channel index of out
//   out_valid      one-cycle pulse when out/out_ch are new
//   busy           high while a sweep is in progress
//
// Each channel takes six cycles: ERR (sample, then compute error), MUL_P,
// MUL_I, MUL_D, SUM.

module pid_mc #(
    parameter int  D_WIDTH = 16,
    parameter int  Q_BITS  = 13,
    parameter int  N_CH    = 4,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rstb,
    input  logic                    write_enable,
    input  logic                    iterate_enable,
    input  logic [D_WIDTH-1:0]      reg_addr,
    input  logic [D_WIDTH-1:0]      reg_data,
    input  logic [N_CH*D_WIDTH-1:0] target,
    input  logic [N_CH*D_WIDTH-1:0] measurement,
    output logic [D_WIDTH-1:0]      out,
    output logic [CH_W-1:0]         out_ch,
    output logic                    out_valid,
    output logic                    busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_ERR, S_MUL_P, S_MUL_I, S_MUL_D, S_SUM
    } state_t;

    localparam int PW = 2*D_WIDTH + 1;
    localparam int SW = 2*D_WIDTH + 2;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);
    localparam logic signed [SW-1:0] Y_MAX = $signed({{(D_WIDTH+3){1'b0}}, {(D_WIDTH-1){1'b1}}});
    localparam logic signed [SW-1:0] Y_MIN = ~Y_MAX;

    // Per-channel register file and loop state
    logic signed [D_WIDTH-1:0] kp      [N_CH];
    logic signed [D_WIDTH-1:0] ki      [N_CH];
    logic signed [D_WIDTH-1:0] kd      [N_CH];
    logic        [D_WIDTH-2:0] int_lim [N_CH];
    logic signed [D_WIDTH-1:0] integ   [N_CH];
    logic signed [D_WIDTH-1:0] e_prev  [N_CH];
`ifdef PID_DEADBAND_EN
    logic        [D_WIDTH-1:0] deadband [N_CH];
`endif

    logic [CH_W-1:0] wr_ch;
    logic            wr_ok;
    logic            unused_addr;

    assign wr_ch       = reg_addr[3 +: CH_W];
    assign wr_ok       = !write_enable && (int'(wr_ch) < N_CH);
    assign unused_addr = ^reg_addr[D_WIDTH-1:3+CH_W];

    always_ff @(posedge clk) begin
        if (!rstb) begin
            for (int c = 0; c < N_CH; c++) begin
                kp[c]      <= '0;
                ki[c]      <= '0;
                kd[c]      <= '0;
                int_lim[c] <= '1;
`ifdef PID_DEADBAND_EN
                deadband[c] <= '0;
`endif
            end
        end else if (wr_ok) begin
            case (reg_addr[2:0])
                3'd0: kp[wr_ch]      <= reg_data;
                3'd1: ki[wr_ch]      <= reg_data;
                3'd2: kd[wr_ch]      <= reg_data;
                3'd3: int_lim[wr_ch] <= reg_data[D_WIDTH-2:0];
`ifdef PID_DEADBAND_EN
                3'd4: deadband[wr_ch] <= reg_data;
`endif
                default: ;
            endcase
        end
    end

    // Sequencer
    state_t          state, state_nxt;
    logic [CH_W-1:0] ch, ch_nxt;
    logic            err_phase, err_phase_nxt;

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state     <= S_IDLE;
            ch        <= '0;
            err_phase <= 1'b0;
        end else begin
            state     <= state_nxt;
            ch        <= ch_nxt;
            err_phase <= err_phase_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        ch_nxt        = ch;
        err_phase_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (iterate_enable) begin
                    state_nxt = S_ERR;
                    ch_nxt    = '0;
                end
            end
            // ERR spends one cycle sampling inputs and one computing the error
            S_ERR: begin
                if (!err_phase) err_phase_nxt = 1'b1;
                else            state_nxt     = S_MUL_P;
            end
            S_MUL_P: state_nxt = S_MUL_I;
            S_MUL_I: state_nxt = S_MUL_D;
            S_MUL_D: state_nxt = S_SUM;
            S_SUM: begin
                if (ch != LAST_CH) begin
                    state_nxt = S_ERR;
                    ch_nxt    = ch + CH_W'(1);
                end else if (iterate_enable) begin
                    state_nxt = S_ERR;
                    ch_nxt    = '0;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

    // Datapath
    logic signed [D_WIDTH-1:0] t_smp, m_smp, e_reg;
    logic signed [D_WIDTH:0]   e_diff;
    logic signed [D_WIDTH-1:0] e_sat, e_new;
    logic signed [PW-1:0]      p_reg, d_reg;
`ifdef PID_DEADBAND_EN
    logic [D_WIDTH:0] e_ext, e_abs;
`endif

    always_comb begin
        e_diff = {t_smp[D_WIDTH-1], t_smp} - {m_smp[D_WIDTH-1], m_smp};
        if (e_diff[D_WIDTH] != e_diff[D_WIDTH-1])
            e_sat = e_diff[D_WIDTH] ? {1'b1, {(D_WIDTH-1){1'b0}}} : {1'b0, {(D_WIDTH-1){1'b1}}};
        else
            e_sat = e_diff[D_WIDTH-1:0];
        e_new = e_sat;
`ifdef PID_DEADBAND_EN
        e_ext = {e_sat[D_WIDTH-1], e_sat};
        e_abs = e_sat[D_WIDTH-1] ? (~e_ext + 1'b1) : e_ext;
        if (e_abs <= {1'b0, deadband[ch]}) e_new = '0;
`endif
    end

    // Single shared multiplier; each gain is read only in its own state
    logic signed [D_WIDTH-1:0] mul_gain;
    logic signed [D_WIDTH:0]   mul_opnd;
    logic signed [PW-1:0]      prod, prod_q;

    always_comb begin
        mul_gain = '0;
        mul_opnd = '0;
        case (state)
            S_MUL_P: begin mul_gain = kp[ch]; mul_opnd = {e_reg[D_WIDTH-1], e_reg}; end
            S_MUL_I: begin mul_gain = ki[ch]; mul_opnd = {e_reg[D_WIDTH-1], e_reg}; end
            S_MUL_D: begin
                mul_gain = kd[ch];
                mul_opnd = {e_reg[D_WIDTH-1], e_reg} - {e_prev[ch][D_WIDTH-1], e_prev[ch]};
            end
            default: ;
        endcase
    end

    assign prod   = mul_gain * mul_opnd;
    assign prod_q = prod >>> Q_BITS;

    logic signed [SW-1:0]      i_sum, lim_pos, lim_neg, y_sum;
    logic signed [D_WIDTH-1:0] i_clamp, y_sat;

    always_comb begin
        lim_pos = $signed({{(D_WIDTH+3){1'b0}}, int_lim[ch]});
        lim_neg = -lim_pos;
        i_sum   = $signed({{(D_WIDTH+2){integ[ch][D_WIDTH-1]}}, integ[ch]})
                + $signed({prod_q[PW-1], prod_q});
        if (i_sum > lim_pos)      i_clamp = lim_pos[D_WIDTH-1:0];
        else if (i_sum < lim_neg) i_clamp = lim_neg[D_WIDTH-1:0];
        else                      i_clamp = i_sum[D_WIDTH-1:0];

        y_sum = $signed({p_reg[PW-1], p_reg})
              + $signed({{(D_WIDTH+2){integ[ch][D_WIDTH-1]}}, integ[ch]})
              + $signed({d_reg[PW-1], d_reg});
        if (y_sum > Y_MAX)      y_sat = Y_MAX[D_WIDTH-1:0];
        else if (y_sum < Y_MIN) y_sat = Y_MIN[D_WIDTH-1:0];
        else                    y_sat = y_sum[D_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            for (int c = 0; c < N_CH; c++) begin
                integ[c]  <= '0;
                e_prev[c] <= '0;
            end
            t_smp     <= '0;
            m_smp     <= '0;
            e_reg     <= '0;
            p_reg     <= '0;
            d_reg     <= '0;
            out       <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_ERR: begin
                    if (!err_phase) begin
                        t_smp <= target[int'(ch)*D_WIDTH +: D_WIDTH];
                        m_smp <= measurement[int'(ch)*D_WIDTH +: D_WIDTH];
                    end else begin
                        e_reg <= e_new;
                    end
                end
                S_MUL_P: p_reg     <= prod_q;
                S_MUL_I: integ[ch] <= i_clamp;
                S_MUL_D: begin
                    d_reg      <= prod_q;
                    e_prev[ch] <= e_reg;
                end
                S_SUM: begin
                    out       <= y_sat;
                    out_ch    <= ch;
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pid_mc.sv
// tb/tb_pid_mc.sv - self-checking bench for pid_mc against a behavioural PID model

module tb_pid_mc;

    localparam int DW  = 16;
    localparam int Q   = 13;
    localparam int NCH = 3;
    localparam int CW  = 2;

    logic            clk = 1'b0;
    logic            rstb, write_enable, iterate_enable;
    logic [DW-1:0]   reg_addr, reg_data;
    logic [NCH*DW-1:0] target, measurement;
    logic [DW-1:0]   out;
    logic [CW-1:0]   out_ch;
    logic            out_valid, busy;

    pid_mc #(.D_WIDTH(DW), .Q_BITS(Q), .N_CH(NCH)) dut (
        .clk(clk), .rstb(rstb), .write_enable(write_enable),
        .iterate_enable(iterate_enable), .reg_addr(reg_addr), .reg_data(reg_data),
        .target(target), .measurement(measurement), .out(out), .out_ch(out_ch),
        .out_valid(out_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    int m_kp[NCH], m_ki[NCH], m_kd[NCH], m_lim[NCH], m_db[NCH];
    longint m_integ[NCH], m_eprev[NCH];
    int tgt[NCH], mes[NCH];
    int exp_out[NCH];

    int got_out[2*NCH], got_ch[2*NCH], got_cyc[2*NCH];
    int got_n, sweep_start;

    function automatic longint sat16(longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_kp[c] = 0; m_ki[c] = 0; m_kd[c] = 0; m_lim[c] = 32767; m_db[c] = 0;
            m_integ[c] = 0; m_eprev[c] = 0;
        end
    endtask

    task automatic model_step(input int c, output int y);
        longint e, p, i, d, lim;
        e = sat16(longint'(tgt[c]) - longint'(mes[c]));
`ifdef PID_DEADBAND_EN
        if ((e < 0 ? -e : e) <= m_db[c]) e = 0;
`endif
        p   = (longint'(m_kp[c]) * e) >>> Q;
        lim = m_lim[c];
        i   = m_integ[c] + ((longint'(m_ki[c]) * e) >>> Q);
        if (i > lim)  i = lim;
        if (i < -lim) i = -lim;
        m_integ[c] = i;
        d = (longint'(m_kd[c]) * (e - m_eprev[c])) >>> Q;
        m_eprev[c] = e;
        y = int'(sat16(p + i + d));
    endtask

    task automatic wr(input int ch, input int fld, input int data, input int hi = 0);
        logic [15:0] d16;
        d16 = 16'(data);
        @(negedge clk);
        write_enable = 1'b0;
        reg_addr     = 16'((ch << 3) | fld | (hi << 10));
        reg_data     = d16;
        @(negedge clk);
        write_enable = 1'b1;
        if (ch < NCH) begin
            case (fld)
                0: m_kp[ch]  = int'($signed(d16));
                1: m_ki[ch]  = int'($signed(d16));
                2: m_kd[ch]  = int'($signed(d16));
                3: m_lim[ch] = int'(d16 & 16'h7fff);
`ifdef PID_DEADBAND_EN
                4: m_db[ch]  = int'(d16);
`endif
                default: ;
            endcase
        end
    endtask

    task automatic drive_inputs();
        for (int c = 0; c < NCH; c++) begin
            target[c*DW +: DW]      = 16'(tgt[c]);
            measurement[c*DW +: DW] = 16'(mes[c]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstb = 1'b0; write_enable = 1'b1; iterate_enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstb = 1'b1;
        model_reset();
    endtask

    task automatic collect(input int n, input int budget);
        got_n = 0;
        for (int k = 0; k < budget && got_n < n; k++) begin
            @(negedge clk);
            if (out_valid) begin
                got_out[got_n] = int'($signed(out));
                got_ch[got_n]  = int'(out_ch);
                got_cyc[got_n] = cyc;
                got_n++;
            end
        end
    endtask

    // One sweep with iterate_enable pulsed for a single cycle
    task automatic do_sweep();
        @(negedge clk);
        drive_inputs();
        for (int c = 0; c < NCH; c++) model_step(c, exp_out[c]);
        iterate_enable = 1'b1;
        @(negedge clk);
        iterate_enable = 1'b0;
        sweep_start = cyc;
        collect(NCH, 60);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (out !== '0)       begin errors++; $display("FAIL reset_out: got %0d expected 0", out); end
        checks++; if (out_ch !== '0)    begin errors++; $display("FAIL reset_out_ch: got %0d expected 0", out_ch); end
        checks++; if (out_valid !== 0)  begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        checks++; if (busy !== 0)       begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        // zero gains: every channel yields 0
        for (int c = 0; c < NCH; c++) begin tgt[c] = 1000 + 100*c; mes[c] = -50; end
        do_sweep();
        for (int c = 0; c < NCH; c++) begin
            checks++;
            if (got_out[c] !== 0) begin errors++; $display("FAIL reset_gain_ch%0d: got %0d expected 0", c, got_out[c]); end
        end
        // reset INT_LIM is full scale, so integration is not clipped at 0
        wr(0, 1, 8192);
        tgt[0] = 1000; mes[0] = 0;
        do_sweep();
        checks++;
        if (got_out[0] !== 1000) begin errors++; $display("FAIL reset_int_lim: got %0d expected 1000", got_out[0]); end
    endtask

    task automatic test_proportional();
        do_reset();
        wr(0, 0, 8192);
        tgt[0] = 1000; mes[0] = 0;
        for (int c = 1; c < NCH; c++) begin tgt[c] = int'($urandom_range(0, 20000)) - 10000; mes[c] = 7; end
        do_sweep();
        checks++;
        if (got_n !== NCH) begin errors++; $display("FAIL prop_pulse_count: got %0d expected %0d", got_n, NCH); end
        for (int c = 0; c < got_n; c++) begin
            checks++;
            if (got_ch[c] !== c) begin errors++; $display("FAIL prop_out_ch%0d: got %0d expected %0d", c, got_ch[c], c); end
            checks++;
            if (got_out[c] !== (c == 0 ? 1000 : 0)) begin errors++; $display("FAIL prop_out_ch%0d: got %0d expected %0d", c, got_out[c], (c == 0 ? 1000 : 0)); end
            checks++;
            if (got_cyc[c] - sweep_start !== 6*(c+1)) begin errors++; $display("FAIL prop_latency_ch%0d: got %0d expected %0d", c, got_cyc[c] - sweep_start, 6*(c+1)); end
        end
        checks++;
        if (busy !== 0) begin errors++; $display("FAIL prop_busy_end: got %0b expected 0", busy); end
    endtask

    task automatic test_integral();
        int want[4];
        want = '{500, 600, 600, 100};
        do_reset();
        wr(1, 1, 8192);
        wr(1, 3, 600);
        tgt[1] = 500; mes[1] = 0;
        for (int s = 0; s < 4; s++) begin
            if (s == 3) tgt[1] = -500;
            do_sweep();
            checks++;
            if (got_out[1] !== want[s]) begin errors++; $display("FAIL integral_s%0d: got %0d expected %0d", s, got_out[1], want[s]); end
        end
    endtask

    task automatic test_derivative();
        int want[3];
        int e_seq[3];
        want = '{100, 200, 0};
        e_seq = '{100, 300, 300};
        do_reset();
        wr(2, 2, 8192);
        for (int s = 0; s < 3; s++) begin
            tgt[2] = e_seq[s]; mes[2] = 0;
            do_sweep();
            checks++;
            if (got_out[2] !== want[s]) begin errors++; $display("FAIL derivative_s%0d: got %0d expected %0d", s, got_out[2], want[s]); end
        end
    endtask

    task automatic test_saturation();
        int t_seq[4], m_seq[4], k_seq[4], want[4];
        t_seq = '{20000, -20000, 32767, -32768};
        m_seq = '{0, 0, -32768, 32767};
        k_seq = '{32767, 32767, 8192, 8192};
        want  = '{32767, -32768, 32767, -32768};
        do_reset();
        for (int s = 0; s < 4; s++) begin
            wr(0, 0, k_seq[s]);
            tgt[0] = t_seq[s]; mes[0] = m_seq[s];
            do_sweep();
            checks++;
            if (got_out[0] !== want[s]) begin errors++; $display("FAIL saturation_s%0d: got %0d expected %0d", s, got_out[0], want[s]); end
        end
    endtask

    // KD written before MUL_D must be used; KP written after MUL_P must not
    task automatic test_mid_channel_write();
        do_reset();
        wr(0, 0, 8192);
        tgt[0] = 100; mes[0] = 0;
        @(negedge clk);
        drive_inputs();
        iterate_enable = 1'b1;
        @(negedge clk);
        iterate_enable = 1'b0;
        write_enable = 1'b0; reg_addr = 16'h0002; reg_data = 16'd8192;
        @(negedge clk);
        write_enable = 1'b1;
        @(negedge clk);
        write_enable = 1'b0; reg_addr = 16'h0000; reg_data = 16'd0;
        @(negedge clk);
        write_enable = 1'b1;
        collect(1, 20);
        checks++;
        if (got_n !== 1 || got_out[0] !== 200) begin errors++; $display("FAIL mid_write: got %0d (pulses %0d) expected 200", got_out[0], got_n); end
        collect(NCH, 30);
    endtask

    task automatic test_back_to_back();
        int exp2[2*NCH];
        int found;
        do_reset();
        for (int c = 0; c < NCH; c++) begin
            wr(c, 0, 2048); wr(c, 1, 4096);
            tgt[c] = int'($urandom_range(0, 4000)) - 2000; mes[c] = int'($urandom_range(0, 400)) - 200;
        end
        for (int s = 0; s < 2; s++)
            for (int c = 0; c < NCH; c++) model_step(c, exp2[s*NCH + c]);
        @(negedge clk);
        drive_inputs();
        iterate_enable = 1'b1;
        collect(2*NCH, 100);
        checks++;
        if (got_n !== 2*NCH) begin errors++; $display("FAIL b2b_pulse_count: got %0d expected %0d", got_n, 2*NCH); end
        for (int k = 0; k < got_n; k++) begin
            checks++;
            if (got_out[k] !== exp2[k] || got_ch[k] !== k % NCH) begin
                errors++; $display("FAIL b2b_out_%0d: got %0d ch %0d expected %0d ch %0d", k, got_out[k], got_ch[k], exp2[k], k % NCH);
            end
            if (k > 0) begin
                checks++;
                if (got_cyc[k] - got_cyc[k-1] !== 6) begin errors++; $display("FAIL b2b_spacing_%0d: got %0d expected 6", k, got_cyc[k] - got_cyc[k-1]); end
            end
        end
        // third sweep: drop iterate_enable while channel 1 is running
        for (int c = 0; c < NCH; c++) model_step(c, exp_out[c]);
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            @(negedge clk);
            if (out_valid) found = 1;
        end
        iterate_enable = 1'b0;
        checks++;
        if (found !== 1 || int'($signed(out)) !== exp_out[0]) begin errors++; $display("FAIL stop_ch0: got %0d expected %0d", $signed(out), exp_out[0]); end
        collect(NCH-1, 40);
        checks++;
        if (got_n !== NCH-1) begin errors++; $display("FAIL stop_pulse_count: got %0d expected %0d", got_n, NCH-1); end
        for (int k = 0; k < got_n; k++) begin
            checks++;
            if (got_out[k] !== exp_out[k+1]) begin errors++; $display("FAIL stop_out_ch%0d: got %0d expected %0d", k+1, got_out[k], exp_out[k+1]); end
        end
        checks++;
        if (busy !== 0) begin errors++; $display("FAIL stop_busy: got %0b expected 0", busy); end
        collect(1, 20);
        checks++;
        if (got_n !== 0) begin errors++; $display("FAIL stop_extra_pulse: got %0d expected 0", got_n); end
    endtask

    task automatic test_reset_mid_sweep();
        do_reset();
        for (int c = 0; c < NCH; c++) begin wr(c, 0, 8192); tgt[c] = 1000; mes[c] = 0; end
        @(negedge clk);
        drive_inputs();
        iterate_enable = 1'b1;
        repeat (14) @(negedge clk);
        rstb = 1'b0;
        iterate_enable = 1'b0;
        @(negedge clk);
        checks++;
        if (out !== '0 || out_ch !== '0 || out_valid !== 0 || busy !== 0) begin
            errors++; $display("FAIL reset_mid_sweep: got out %0d ch %0d valid %0b busy %0b expected all 0", out, out_ch, out_valid, busy);
        end
        rstb = 1'b1;
        model_reset();
        collect(1, 30);
        checks++;
        if (got_n !== 0) begin errors++; $display("FAIL reset_mid_sweep_pulse: got %0d expected 0", got_n); end
    endtask

    task automatic test_bad_channel();
        do_reset();
        wr(0, 0, 8192);
        for (int c = 0; c < NCH; c++) begin tgt[c] = 1000; mes[c] = 0; end
        wr(NCH, 0, 8192);
        wr(NCH, 1, 8192);
        wr(NCH, 3, 0);
        do_sweep();
        for (int c = 0; c < NCH; c++) begin
            checks++;
            if (got_out[c] !== exp_out[c]) begin errors++; $display("FAIL bad_ch_write_ch%0d: got %0d expected %0d", c, got_out[c], exp_out[c]); end
        end
        // high address bits are ignored, so this still targets channel 1
        wr(1, 0, 8192, 1);
        do_sweep();
        checks++;
        if (got_out[1] !== 1000) begin errors++; $display("FAIL addr_upper_bits: got %0d expected 1000", got_out[1]); end
    endtask

    task automatic test_random();
        do_reset();
        for (int s = 0; s < 8; s++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 1) == 1 || s == 0) begin
                    wr(c, 0, int'($urandom_range(0, 16383)) - 8192);
                    wr(c, 1, int'($urandom_range(0, 16383)) - 8192);
                    wr(c, 2, int'($urandom_range(0, 16383)) - 8192);
                    wr(c, 3, int'($urandom_range(0, 65535)));
                end
                tgt[c] = int'($urandom_range(0, 16000)) - 8000;
                mes[c] = int'($urandom_range(0, 16000)) - 8000;
            end
            do_sweep();
            for (int c = 0; c < NCH; c++) begin
                checks++;
                if (got_out[c] !== exp_out[c] || got_ch[c] !== c) begin
                    errors++; $display("FAIL random_s%0d_ch%0d: got %0d ch %0d expected %0d", s, c, got_out[c], got_ch[c], exp_out[c]);
                end
            end
        end
    endtask

`ifdef PID_DEADBAND_EN
    task automatic test_deadband();
        do_reset();
        wr(0, 4, 50);
        wr(0, 0, 8192);
        wr(0, 1, 8192);
        tgt[0] = 40; mes[0] = 0;
        do_sweep();
        checks++;
        if (got_out[0] !== 0) begin errors++; $display("FAIL deadband_inside: got %0d expected 0", got_out[0]); end
        tgt[0] = 60;
        do_sweep();
        checks++;
        if (got_out[0] !== 120) begin errors++; $display("FAIL deadband_outside: got %0d expected 120", got_out[0]); end
    endtask
`endif

    initial begin
        rstb = 1'b0; write_enable = 1'b1; iterate_enable = 1'b0;
        reg_addr = '0; reg_data = '0; target = '0; measurement = '0;
        for (int c = 0; c < NCH; c++) begin tgt[c] = 0; mes[c] = 0; end
        model_reset();
        test_reset();
        test_proportional();
        test_integral();
        test_derivative();
        test_saturation();
        test_mid_channel_write();
        test_back_to_back();
        test_reset_mid_sweep();
        test_bad_channel();
        test_random();
`ifdef PID_DEADBAND_EN
        test_deadband();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pid_mc.md
Name: pid_mc

Overview:
Time-multiplexed multi-channel PID controller and the parametrised successor of the single-channel pid block. N_CH independent loops share one multiplier, and a sequencer sweeps the channels in order. Each loop has its own gains, integrator limit, integrator state and previous error, all held in a register file written over the existing reg_addr/reg_data/write_enable interface. Data is signed fixed point with Q_BITS fractional bits.

Parameters:
D_WIDTH, 16, sample, gain and output width (signed two's complement)
Q_BITS, 13, fractional bits of gains and products
N_CH, 4, number of channels (1..8)
CH_W, $clog2(N_CH) (min 1), channel index width (derived, do not override)

Ports:
clk  in  1  clock
rstb  in  1  synchronous active-low reset
write_enable  in  1  active-low register write strobe
iterate_enable  in  1  high = run sweeps continuously
reg_addr  in  D_WIDTH  [2:0] field, [3+CH_W-1:3] channel; upper bits ignored
reg_data  in  D_WIDTH  write data
target  in  N_CH*D_WIDTH  per-channel setpoint; ch c at [c*D_WIDTH +: D_WIDTH]
measurement  in  N_CH*D_WIDTH  per-channel process variable, same packing
out  out  D_WIDTH  controller output of channel out_ch
out_ch  out  CH_W  channel index of out
out_valid  out  1  one-cycle pulse when out/out_ch are new
busy  out  1  high while a sweep is in progress

Behaviour:
- Reset is synchronous on clk while rstb=0. KP/KI/KD=0, INT_LIM=+max (2^(D_WIDTH-1)-1), integrators=0, e_prev=0. out=0, out_ch=0, out_valid=0, busy=0. FSM goes to IDLE. Reset mid-sweep aborts the sweep with no further out_valid.
- Register fields: 0 KP, 1 KI, 2 KD, 3 INT_LIM (treated as unsigned magnitude, MSB ignored). Fields 5-7 are ignored.
- A write happens on a rising clk edge when write_enable=0 and becomes visible the next cycle. Writes are accepted while busy=1. A write to channel >= N_CH is ignored.
- FSM: IDLE -> ERR -> MUL_P -> MUL_I -> MUL_D -> SUM -> (next channel ERR | IDLE).
- IDLE -> ERR for ch 0 when iterate_enable=1. busy=1 in every state except IDLE.
- ERR: sample target[c] and measurement[c], then compute e = target - measurement in D_WIDTH+1 bits, saturated to signed D_WIDTH.
- MUL_P: P = (KP*e) >>> Q_BITS, using the 2*D_WIDTH product with an arithmetic shift (floor).
- MUL_I: I_new = I + ((KI*e) >>> Q_BITS), clamped to [-INT_LIM, +INT_LIM], then stored to that channel's integrator.
- MUL_D: D = (KD*(e - e_prev)) >>> Q_BITS, with the difference in D_WIDTH+1 bits. e_prev[c] <= e.
- Each gain is read in its own MUL state, so a write landing mid-channel affects only the terms not yet computed.
- SUM: y = P + I_new + D in 2*D_WIDTH+2 bits, saturated to signed D_WIDTH. out <= y and out_ch <= c are registered, and out_valid pulses in the cycle after SUM.
- Latency: out_valid for channel c occurs 6 cycles after its ERR entry. A sweep takes 6*N_CH cycles.
- After SUM of ch N_CH-1: if iterate_enable=1, go straight to ERR ch 0 (back-to-back sweeps, no gap). Otherwise go to IDLE.
- Deasserting iterate_enable mid-sweep does not abort; the sweep completes through ch N_CH-1.
- Outputs hold their value between out_valid pulses.

Optional Feature:
PID_DEADBAND_EN:
- Defined: field 4 is a per-channel DEADBAND (unsigned, reset 0). In ERR, if |e| <= DEADBAND then e is forced to 0 (P=0, no integration, and e_prev is updated to 0).
- Undefined: field 4 is ignored and there is no deadband logic.

Test Plan:
- Proportional: ch0 KP=8192 (1.0), others 0; target0=1000, measurement0=0, one sweep -> out_ch=0, out=1000. Unconfigured channels give out=0. out_valid pulses N_CH times, 6 cycles apart.
- Integral with anti-windup: ch1 KI=8192, INT_LIM=600, e=500, three sweeps -> outputs 500, 600, 600. Then e=-500 -> 100.
- Derivative: ch2 KD=8192, e=100 then e=300 on consecutive sweeps -> outputs 100, 200. With e held at 300 -> 0.
- Saturation: KP=32767, e=20000 -> out=32767. e=-20000 -> out=-32768. Error saturation: target=32767, measurement=-32768 -> e=32767. With KP=8192 -> out=32767.
- Control/reset: drop iterate_enable during ch1 of a sweep -> ch2..N_CH-1 still produce output, then busy=0. Pulse rstb=0 mid-sweep -> no out_valid, and all outputs are 0 the cycle after. A write to channel index N_CH leaves all registers unchanged.
- PID_DEADBAND_EN: DEADBAND=50, KP=8192, KI=8192, e=40 -> out=0 and integrator stays 0. e=60 -> out=120 (P=60, I=60).
